mul_mod_arbiter: RTL and testbench
==================================

// Module: mul_mod_arbiter
// PURPOSE
//  Shares one fully pipelined mul_mod (a*b mod Q, Q = 12587009, 24-bit operands) among NREQ requesters.
//  Performs a round-robin grant, issues at most one multiply per cycle and carries requester id plus
//  user tag through a valid/tag shift pipeline matched to the multiplier latency.
//  Results return on one shared bus, stamped with the id and tag. Sits between NTT butterfly/pointwise
//  controllers and the single modular multiplier.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  IDW      2   requester id width, = clog2(NREQ)
//  TAGW     8   user tag width, returned unchanged with the result
//  MUL_LAT  10  mul_mod latency in cycles, from operand accept to registered out
// PORTS
//  clk        in   1          clock, all logic on posedge
//  reset      in   1          synchronous, active-high
//  en         in   1          issue enable; low = no new grants, in-flight ops still complete
//  req_valid  in   NREQ       requester i has an operand pair
//  req_ready  out  NREQ       one-hot grant; transfer when req_valid[i] & req_ready[i]
//  req_a      in   NREQ*24    operand a, slice i = [24*i +: 24], must be < Q
//  req_b      in   NREQ*24    operand b, same slicing, must be < Q
//  req_tag    in   NREQ*TAGW  user tag per requester
//  res_valid  out  1          one-cycle pulse per completed op; no backpressure
//  res_id     out  IDW        requester index of the result
//  res_tag    out  TAGW       tag captured at issue
//  res_data   out  24         (a*b) mod Q
//  busy       out  1          high while any op is in flight
// BEHAVIOUR
//  - Reset: req_ready=0, res_valid=0, res_id=0, res_tag=0, busy=0, rr_ptr=NREQ-1.
//    The valid pipeline clears, so in-flight ops are discarded and never reported.
//  - The mul_mod datapath has no reset. res_data is don't-care while res_valid=0.
//  - Grant is combinational from req_valid, rr_ptr, en and reset. It is the first i with req_valid[i]=1,
//    searching (rr_ptr+1) mod NREQ upward with wrap. At most one bit is set. All zero when en=0 or reset=1.
//  - req_ready[i] never asserts unless req_valid[i]=1.
//  - On a transfer, rr_ptr<=i and the operands drive mul_mod a/b in the same cycle.
//    {1,i,tag} enters the MUL_LAT-deep tag pipeline. With no transfer, a 0 valid bit enters.
//  - Latency: a transfer in cycle t gives res_valid=1 in cycle t+MUL_LAT with the matching id, tag and data.
//  - Order: results leave in issue order, with full throughput of 1 op/cycle.
//  - Simultaneous requests: round-robin with no starvation. A requester waits at most NREQ-1 grants.
//  - en falling: no new grants from that cycle; already-issued ops complete normally.
//  - busy = OR of the pipeline valid bits.
//  - Operands >= Q: result undefined. With MUL_MOD_ARB_CHECK_EN defined, such operands are flagged (see below).
//  - Reset asserted mid-stream: pipeline cleared next edge, no stale res_valid afterwards.
// CONFIGURATION
//  MUL_MOD_ARB_PRIO_EN: when defined, requester 0 has fixed priority over the round-robin. If req_valid[0]=1
//    it is always granted, and rr_ptr is left unchanged by grants to 0. Requesters 1..NREQ-1 round-robin
//    among themselves. Not defined: pure round-robin over all NREQ.
//    (MUL_MOD_ARB_CHECK_EN is an optional debug assertion macro only, simulation-only, not synthesised.)
// STRUCTURE
//  - Shared package (ntru_ntt_pkg): localparam Q=24'd12587009, COEF_W=24, MUL_MOD_LAT=10.
//  - Sub-module: one mul_mod instance (clk, resetn tied to ~reset, a, b, out).
//  - Local logic: rotate-priority encoder, rr_ptr register, tag shift register of MUL_LAT x (1+IDW+TAGW) bits.
//  - Output regs: res_id and res_tag are the pipeline tail; res_data is mul_mod out.
// TESTING
//  1. Single op: req 1 sends a=3, b=5, tag=0x11 at t -> at t+10: res_valid=1, id=1, tag=0x11, data=15; busy 0 by t+11.
//  2. Wrap/mod: a=b=12587008 -> data=1; a=12587008, b=2 -> data=12587007; a=0, b=9 -> data=0.
//  3. Fairness: all 4 hold req_valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; 8 results 10 cycles later in that order.
//  4. Back-to-back: req 2 streams 20 ops, a=k, b=k+1 -> 20 consecutive res_valid, data=k*(k+1) mod Q, tags in order.
//  5. en=0 with req_valid=4'b1111 -> req_ready=0, no results. Release en -> grant goes to (rr_ptr+1) mod 4.
//  6. Reset 4 cycles after 3 issues -> no res_valid ever appears for them; busy=0 after the reset edge.
//     With MUL_MOD_ARB_PRIO_EN, req 0 and req 3 both valid -> req 0 is granted every cycle.

Source files
------------

// File: rtl/ntru_ntt_pkg.sv
// Shared constants for the NTRU NTT datapath: modulus, coefficient width, multiplier latency
// and the Barrett reduction constant used by mul_mod.
package ntru_ntt_pkg;

  localparam int unsigned COEF_W      = 24;
  localparam logic [COEF_W-1:0] Q     = 24'd12587009;
  localparam int unsigned MUL_MOD_LAT = 10;

  // floor(2^48 / Q); Q has bit length 24, so the quotient estimate is at most 2 low
  localparam logic [COEF_W:0] BARRETT_MU = 25'((64'd1 << (2 * COEF_W)) / 64'(Q));

  typedef logic [COEF_W-1:0] coef_t;

endpackage

// File: rtl/mul_mod.sv
// Fully pipelined (a*b) mod Q with Barrett reduction; MUL_MOD_LAT register stages from operand
// capture to the registered output. Datapath carries no reset.
module mul_mod
  import ntru_ntt_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  coef_t a,
  input  coef_t b,
  output coef_t out
);

  // Remainder before correction is below 3Q < 2^26, so 26-bit arithmetic is exact
  localparam int unsigned RW = 26;
  localparam int unsigned PW = 2 * COEF_W;

  coef_t              a_q, b_q;
  logic [PW-1:0]      prod_q, prod_rt_q;
  logic [COEF_W:0]    qe_q, qe_rt_q;
  logic [RW-1:0]      qq_q, qq_rt_q;
  logic [3:0][RW-1:0] plo_q;
  logic [RW-1:0]      r_q, r1_q;
  coef_t              out_q;

  always_ff @(posedge clk) begin
    // Squash operands while held in reset so the datapath does not chew on garbage
    a_q       <= resetn ? a : '0;
    b_q       <= resetn ? b : '0;
    prod_q    <= {{COEF_W{1'b0}}, a_q} * {{COEF_W{1'b0}}, b_q};
    prod_rt_q <= prod_q;
    qe_q      <= 25'(({25'd0, prod_rt_q[PW-1:COEF_W-1]} * {25'd0, BARRETT_MU}) >> (COEF_W + 1));
    plo_q     <= {plo_q[2:0], prod_rt_q[RW-1:0]};
    qe_rt_q   <= qe_q;
    qq_q      <= RW'(qe_rt_q) * RW'(Q);
    qq_rt_q   <= qq_q;
    r_q       <= plo_q[3] - qq_rt_q;
    r1_q      <= (r_q >= RW'(Q)) ? r_q - RW'(Q) : r_q;
    out_q     <= (r1_q >= RW'(Q)) ? COEF_W'(r1_q - RW'(Q)) : COEF_W'(r1_q);
  end

  assign out = out_q;

endmodule

// File: rtl/mul_mod_arbiter.sv
// Round-robin arbiter sharing one pipelined mul_mod among NREQ requesters, returning results
// stamped with requester id and tag. Optional MUL_MOD_ARB_PRIO_EN gives requester 0 fixed
// priority; optional MUL_MOD_ARB_CHECK_EN adds a simulation-only operand range assertion.
module mul_mod_arbiter
  import ntru_ntt_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TAGW    = 8,
  // Must equal MUL_MOD_LAT so the tag pipeline lines up with the multiplier output
  parameter int unsigned MUL_LAT = MUL_MOD_LAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*COEF_W-1:0] req_a,
  input  logic [NREQ*COEF_W-1:0] req_b,
  input  logic [NREQ*TAGW-1:0]   req_tag,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic [TAGW-1:0]        res_tag,
  output logic [COEF_W-1:0]      res_data,
  output logic                   busy
);

  logic [IDW-1:0]               rr_ptr_q;
  logic [NREQ-1:0]              grant;
  logic [NREQ-1:0]              cand;
  logic [IDW-1:0]               grant_idx;
  logic                         found;
  logic                         fire;
  logic                         ptr_upd;
  int unsigned                  slot;
  coef_t                        mul_a, mul_b;
  logic [TAGW-1:0]              issue_tag;
  logic [MUL_LAT-1:0]           vld_q;
  logic [MUL_LAT-1:0][IDW-1:0]  id_q;
  logic [MUL_LAT-1:0][TAGW-1:0] tag_q;

  // Rotating priority search starting just after the last granted requester
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    slot      = 0;
    cand      = req_valid;
`ifdef MUL_MOD_ARB_PRIO_EN
    cand[0]   = 1'b0;
`endif
    if (en && !reset) begin
`ifdef MUL_MOD_ARB_PRIO_EN
      if (req_valid[0]) begin
        found = 1'b1;
      end
`endif
      for (int unsigned k = 1; k <= NREQ; k++) begin
        slot = (int'(rr_ptr_q) + int'(k)) % NREQ;
        if (!found && cand[slot]) begin
          found     = 1'b1;
          grant_idx = IDW'(slot);
        end
      end
      if (found) begin
        grant[grant_idx] = 1'b1;
      end
    end
  end

  assign fire      = |grant;
  assign req_ready = grant;
  assign mul_a     = req_a[COEF_W*grant_idx +: COEF_W];
  assign mul_b     = req_b[COEF_W*grant_idx +: COEF_W];
  assign issue_tag = req_tag[TAGW*grant_idx +: TAGW];

`ifdef MUL_MOD_ARB_PRIO_EN
  // Grants to the priority requester leave the rotation untouched
  assign ptr_upd = fire && (grant_idx != '0);
`else
  assign ptr_upd = fire;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= IDW'(NREQ - 1);
      vld_q    <= '0;
      id_q     <= '0;
      tag_q    <= '0;
    end else begin
      if (ptr_upd) begin
        rr_ptr_q <= grant_idx;
      end
      vld_q <= {vld_q[MUL_LAT-2:0], fire};
      id_q  <= {id_q[MUL_LAT-2:0], grant_idx};
      tag_q <= {tag_q[MUL_LAT-2:0], issue_tag};
    end
  end

  mul_mod u_mul_mod (
    .clk    (clk),
    .resetn (~reset),
    .a      (mul_a),
    .b      (mul_b),
    .out    (res_data)
  );

  assign res_valid = vld_q[MUL_LAT-1];
  assign res_id    = id_q[MUL_LAT-1];
  assign res_tag   = tag_q[MUL_LAT-1];
  assign busy      = |vld_q;

`ifdef MUL_MOD_ARB_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset && fire) begin
      assert (mul_a < Q && mul_b < Q)
        else $error("mul_mod_arbiter: operand >= Q from requester %0d", grant_idx);
    end
  end
`endif

endmodule

// File: tb/tb_mul_mod_arbiter.sv
// Self-checking bench for mul_mod_arbiter: directed steps plus random traffic against a
// queue-based reference model of grants, results and busy.
module tb_mul_mod_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TAGW = 8;
  localparam int LAT  = 10;
  localparam longint QV = 64'd12587009;
  localparam int unsigned QMAX = 32'd12587008;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*24-1:0]   req_a;
  logic [NREQ*24-1:0]   req_b;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [TAGW-1:0]      res_tag;
  logic [23:0]          res_data;
  logic                 busy;

  mul_mod_arbiter #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TAGW    (TAGW),
    .MUL_LAT (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int rq; logic [23:0] a; logic [23:0] b; logic [7:0] tag; } op_t;
  typedef struct { int due; int id; logic [7:0] tag; logic [23:0] data; } res_t;

  op_t             pend[$];
  res_t            sb[$];
  int              ptr;
  int              cyc;
  int              n_cmp;
  int              n_fail;
  logic [NREQ-1:0] last_ready;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
      end
  endtask

  task automatic add_op(input int rq, input logic [23:0] a, input logic [23:0] b,
                        input logic [7:0] tag);
    op_t o;
    o.rq = rq; o.a = a; o.b = b; o.tag = tag;
    pend.push_back(o);
  endtask

  function automatic int first_pend(input int r);
    for (int j = 0; j < pend.size(); j++) if (pend[j].rq == r) return j;
    return -1;
  endfunction

  // Reference arbitration: first valid requester after the last rotating grant
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int g = -1;
`ifdef MUL_MOD_ARB_PRIO_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) if (g < 0 && v[(p + k) % NREQ]) g = (p + k) % NREQ;
    return g;
  endfunction

  // One clock: drive, check at negedge, advance the model, step past the posedge
  task automatic cycle();
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] eg;
    int g;
    int j;
    res_t r;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = first_pend(i);
      req_a[24*i +: 24]     = (j >= 0) ? pend[j].a : 24'd0;
      req_b[24*i +: 24]     = (j >= 0) ? pend[j].b : 24'd0;
      req_tag[TAGW*i +: TAGW] = (j >= 0) ? pend[j].tag : 8'd0;
      v[i] = (j >= 0);
    end
    req_valid = v;
    @(negedge clk);
    g  = (en && !reset) ? pick(v, ptr) : -1;
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    last_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("busy", 32'(busy), 32'(sb.size() != 0));
    if (sb.size() != 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_id", 32'(res_id), 32'(r.id));
      chk("res_tag", 32'(res_tag), 32'(r.tag));
      chk("res_data", 32'(res_data), 32'(r.data));
    end else begin
      chk("res_valid", 32'(res_valid), 32'd0);
    end
    if (reset) begin
      sb.delete();
      ptr = NREQ - 1;
    end else if (g >= 0) begin
      j = first_pend(g);
      r.due  = cyc + LAT;
      r.id   = g;
      r.tag  = pend[j].tag;
      r.data = 24'((longint'(pend[j].a) * longint'(pend[j].b)) % QV);
      sb.push_back(r);
      pend.delete(j);
`ifdef MUL_MOD_ARB_PRIO_EN
      if (g != 0) ptr = g;
`else
      ptr = g;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (sb.size() != 0 || pend.size() != 0); i++) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; ptr = NREQ - 1;
    reset = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cycle();
    reset = 1'b0;
    en    = 1'b1;
    run(2);

    // Single op
    add_op(1, 24'd3, 24'd5, 8'h11);
    run(13);

    // Modular wrap-around corners
    add_op(0, 24'(QMAX), 24'(QMAX), 8'h21);
    add_op(0, 24'(QMAX), 24'd2, 8'h22);
    add_op(0, 24'd0, 24'd9, 8'h23);
    drain();

`ifndef MUL_MOD_ARB_PRIO_EN
    // Fairness from a fresh pointer: 0,1,2,3,0,1,2,3
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int r = 0; r < NREQ; r++)
      for (int n = 0; n < 2; n++) add_op(r, 24'($urandom_range(QMAX)), 24'($urandom_range(QMAX)),
                                         8'(16 * r + n));
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("fair_grant", 32'(last_ready), 32'd1 << (k % NREQ));
    end
`else
    // Requester 0 beats requester 3 while both are valid
    for (int n = 0; n < 5; n++) begin
      add_op(0, 24'($urandom_range(QMAX)), 24'($urandom_range(QMAX)), 8'(n));
      add_op(3, 24'($urandom_range(QMAX)), 24'($urandom_range(QMAX)), 8'(8'h30 + n));
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("prio_grant", 32'(last_ready), 32'd1);
    end
`endif
    drain();

    // Enable low blocks grants; release resumes after the last grant (3 -> 0)
    for (int r = 0; r < NREQ; r++) add_op(r, 24'(r + 100), 24'(r + 7), 8'(8'h40 + r));
    en = 1'b0;
    run(3);
    en = 1'b1;
    cycle();
    chk("en_release", 32'(last_ready), 32'd1);
    drain();

    // Back-to-back stream from requester 2
    for (int k = 0; k < 20; k++) add_op(2, 24'(k), 24'(k + 1), 8'(k));
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("b2b_grant", 32'(last_ready), 32'd4);
    end
    drain();

    // Reset 4 cycles after 3 issues discards them
    for (int k = 0; k < 3; k++) add_op(1, 24'(k + 50), 24'(k + 60), 8'(8'h70 + k));
    run(7);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    run(15);

    // Random traffic with occasional enable drops and resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(3) != 0 && pend.size() < 12)
        add_op(int'($urandom_range(NREQ - 1)), 24'($urandom_range(QMAX)),
               24'($urandom_range(QMAX)), 8'($urandom));
      en    = ($urandom_range(7) != 0);
      reset = ($urandom_range(99) == 0);
      cycle();
      reset = 1'b0;
    end
    en = 1'b1;
    drain();
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
